// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier.
//   state_t  : control FSM states
//   WIDTH_MIN/WIDTH_MAX : legal operand width range
//   cnt_w()  : iteration counter width for a given operand width
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 64;

  // Counter only has to reach WIDTH-1.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mul_adder.sv
// Combinational W-bit adder with carry-out, used for the accumulate step.
//   a, b : addends (WIDTH)
//   sum  : low WIDTH bits of a+b
//   cout : carry-out
module mul_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, one add/shift iteration per clock.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, accepted only while ready=1
//   multiplicand : operand A, sampled on accepted start
//   multiplier   : operand B, sampled on accepted start
//   is_signed    : two's-complement mode (only when SIGNED_MUL_EN is defined)
//   ready        : high in IDLE
//   done         : one-cycle pulse, product valid
//   product      : 2*WIDTH result / live shift register
//   hi           : upper half of product
// WIDTH legal range 4..64. Define SIGNED_MUL_EN to enable signed mode:
// operands are loaded as magnitudes and a final NEG cycle negates the result.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
`ifdef SIGNED_MUL_EN
  input  logic               is_signed,
`endif
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   hi
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic             neg;

  logic [WIDTH-1:0] a_ld, b_ld;
  logic             neg_ld;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Operand conditioning at acceptance. The most negative value's magnitude
  // 2^(W-1) still fits W unsigned bits, so no special case is needed.
  always_comb begin
    a_ld   = multiplicand;
    b_ld   = multiplier;
    neg_ld = 1'b0;
`ifdef SIGNED_MUL_EN
    if (is_signed) begin
      if (multiplicand[WIDTH-1]) a_ld = ~multiplicand + WIDTH'(1);
      if (multiplier[WIDTH-1])   b_ld = ~multiplier + WIDTH'(1);
      neg_ld = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
    end
`endif
  end

  mul_adder #(.WIDTH(WIDTH)) u_add (
    .a    (product[2*WIDTH-1:WIDTH]),
    .b    (mcand),
    .sum  (sum),
    .cout (cout)
  );

  assign hi = product[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      product <= '0;
      mcand   <= '0;
      neg     <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand   <= a_ld;
            product <= {{WIDTH{1'b0}}, b_ld};
            count   <= '0;
            neg     <= neg_ld;
            ready   <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          // Carry-out lands in the product MSB so the full 2W result survives.
          if (product[0]) product <= {cout, sum, product[WIDTH-1:1]};
          else            product <= {1'b0, product[2*WIDTH-1:1]};
          if (count == CW'(WIDTH-1)) begin
            state <= neg ? NEG : DONE;
            done  <= ~neg;
          end else begin
            count <= count + CW'(1);
          end
        end
        NEG: begin
          product <= ~product + (2*WIDTH)'(1);
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        is_signed = 1'b0;
  logic        ready, done;
  logic [15:0] product;
  logic [7:0]  hi;

  logic        start32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        is_signed32 = 1'b0;
  logic        ready32, done32;
  logic [63:0] product32;
  logic [31:0] hi32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(a), .multiplier(b),
`ifdef SIGNED_MUL_EN
    .is_signed(is_signed),
`endif
    .ready(ready), .done(done), .product(product), .hi(hi)
  );

  shift_add_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32),
    .multiplicand(a32), .multiplier(b32),
`ifdef SIGNED_MUL_EN
    .is_signed(is_signed32),
`endif
    .ready(ready32), .done(done32), .product(product32), .hi(hi32)
  );

  // Issue one op on the 8-bit instance; lat = edges from acceptance to done.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic sg,
                        output logic [15:0] p, output int lat);
    int n;
    lat = -1;
    n = 0;
    while (!ready && n < 50) begin @(posedge clk); #1; n++; end
    a = x; b = y; is_signed = sg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    p = product;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (product !== 16'd0) begin n_fail++; $display("FAIL reset_product got %h want 0000", product); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_unsigned();
    logic [7:0]  ta [3] = '{8'd13, 8'd255, 8'd0};
    logic [7:0]  tb [3] = '{8'd11, 8'd255, 8'd200};
    logic [15:0] te [3] = '{16'd143, 16'hFE01, 16'h0000};
    logic [15:0] p;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], 1'b0, p, lat);
      n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL unsigned_lat[%0d] got %0d want 8", i, lat); end
      n_checks++; if (p !== te[i]) begin n_fail++; $display("FAIL unsigned_product[%0d] got %h want %h", i, p, te[i]); end
      if (i == 0) begin
        n_checks++; if (hi !== 8'h00) begin n_fail++; $display("FAIL hi got %h want 00", hi); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %b want 0", done); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after got %b want 1", ready); end
        n_checks++; if (product !== 16'd143) begin n_fail++; $display("FAIL product_hold got %h want 008f", product); end
      end
      if (i == 1) begin
        n_checks++; if (hi !== 8'hFE) begin n_fail++; $display("FAIL hi_ff got %h want fe", hi); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    logic        prev_done = 1'b0;
    int          n_done = 0;
    logic [15:0] e;
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL b2b_unexpected_done cycle %0d", i); end
        else begin
          e = q.pop_front();
          if (product !== e) begin n_fail++; $display("FAIL b2b_product got %h want %h", product, e); end
        end
        if (prev_done) begin n_checks++; n_fail++; $display("FAIL b2b_done_width got 2 cycles want 1"); end
      end
      prev_done = done;
      if (i >= 60) start = 1'b0;
      a = 8'(i * 37 + 5);
      b = 8'(i * 11 + 3);
      if (ready && start) q.push_back(16'(a) * 16'(b));
    end
    n_checks++; if (n_done < 5) begin n_fail++; $display("FAIL b2b_count got %0d want >=5", n_done); end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL b2b_pending got %0d want 0", q.size()); end
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    a = 8'd99; b = 8'd77; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n_checks++; if (product !== 16'd0) begin n_fail++; $display("FAIL midrst_product got %h want 0000", product); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
    for (int i = 0; i < 15; i++) begin @(posedge clk); #1; if (done) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_no_done got %0d want 0", seen); end
  endtask

`ifdef SIGNED_MUL_EN
  task automatic test_signed();
    logic [7:0]  ta [3] = '{8'h80, 8'hFF, 8'hFF};
    logic [7:0]  tb [3] = '{8'h7F, 8'hFF, 8'hFF};
    logic        ts [3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] te [3] = '{16'hC080, 16'h0001, 16'hFE01};
    int          tl [3] = '{9, 8, 8};
    logic [15:0] p;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], ts[i], p, lat);
      n_checks++; if (lat !== tl[i]) begin n_fail++; $display("FAIL signed_lat[%0d] got %0d want %0d", i, lat, tl[i]); end
      n_checks++; if (p !== te[i]) begin n_fail++; $display("FAIL signed_product[%0d] got %h want %h", i, p, te[i]); end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0]  x, y;
    logic        sg;
    logic [15:0] p, e;
    int lat, el;
    for (int i = 0; i < 100; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      sg = 1'b0;
`ifdef SIGNED_MUL_EN
      sg = 1'($urandom);
`endif
      if (sg) e = 16'($signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y}));
      else    e = 16'(x) * 16'(y);
      el = (sg && (x[7] ^ y[7])) ? 9 : 8;
      run_op(x, y, sg, p, lat);
      n_checks++;
      if (p !== e || lat !== el) begin
        n_fail++;
        $display("FAIL random[%0d] %h*%h s=%b got %h lat %0d want %h lat %0d", i, x, y, sg, p, lat, e, el);
      end
    end
  endtask

  task automatic test_wide();
    int lat = -1;
    a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; start32 = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done32) begin lat = i; break; end
    end
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL wide_lat got %0d want 32", lat); end
    n_checks++; if (product32 !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL wide_product got %h want fffffffe00000001", product32); end
    n_checks++; if (hi32 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wide_hi got %h want fffffffe", hi32); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SIGNED_MUL_EN
    test_signed();
`endif
    test_random();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
